// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges ID/EX stall requests, sequences the
// iterative unit through start/done with a timeout, and applies exception flushes.
module pipe_ctrl #(
    parameter int STALL_W    = 6,
    parameter int CNT_W      = 6,
    parameter int MC_TIMEOUT = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id_i,
    input  logic               ex_mc_req_i,
    input  logic               mc_done_i,
    input  logic               flush_i,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_o,
    output logic               mc_start_o,
    output logic               mc_cancel_o,
    output logic               mc_result_valid_o,
    output logic               mc_error_o,
    output logic [1:0]         mc_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(4'b0111);
    localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(4'b1111);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MC_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             cancel_q, cancel_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        cancel_d = 1'b0;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        if (flush_i) begin
            // A result already delivered in DONE needs no abort.
            state_d  = IDLE;
            cnt_d    = '0;
            cancel_d = (state_q == START) || (state_q == BUSY);
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_mc_req_i) begin
                        state_d = START;
                        start_d = 1'b1;
                    end
                end
                START: begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
                BUSY: begin
                    cnt_d = cnt_q + 1'b1;
                    if (mc_done_i) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        error_d  = 1'b1;
                        cancel_d = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            cancel_q <= 1'b0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            cancel_q <= cancel_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    // DONE is deliberately absent from the EX-stall term so the op can leave.
    always_comb begin
        stall_o = STALL_NONE;
        if (rst || flush_i) begin
            stall_o = STALL_NONE;
        end else if ((state_q == START) || (state_q == BUSY) ||
                     ((state_q == IDLE) && ex_mc_req_i)) begin
            stall_o = STALL_EX;
        end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
        end
    end

    assign flush_o           = flush_i & ~rst;
    assign mc_start_o        = start_q;
    assign mc_cancel_o       = cancel_q;
    assign mc_result_valid_o = valid_q;
    assign mc_error_o        = error_q;
    assign mc_state_o        = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-computed stall vectors and FSM pulses.
module tb_pipe_ctrl;

    localparam int STALL_W    = 6;
    localparam int CNT_W      = 6;
    localparam int MC_TIMEOUT = 40;

    logic               clk = 1'b0;
    logic               rst;
    logic               stallreq_id_i;
    logic               ex_mc_req_i;
    logic               mc_done_i;
    logic               flush_i;
    logic [STALL_W-1:0] stall_o;
    logic               flush_o;
    logic               mc_start_o;
    logic               mc_cancel_o;
    logic               mc_result_valid_o;
    logic               mc_error_o;
    logic [1:0]         mc_state_o;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(
        .STALL_W    (STALL_W),
        .CNT_W      (CNT_W),
        .MC_TIMEOUT (MC_TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_id_i     (stallreq_id_i),
        .ex_mc_req_i       (ex_mc_req_i),
        .mc_done_i         (mc_done_i),
        .flush_i           (flush_i),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .mc_start_o        (mc_start_o),
        .mc_cancel_o       (mc_cancel_o),
        .mc_result_valid_o (mc_result_valid_o),
        .mc_error_o        (mc_error_o),
        .mc_state_o        (mc_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven for that cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; stallreq_id_i = 1'b0; ex_mc_req_i = 1'b0; mc_done_i = 1'b0; flush_i = 1'b0;
        step();
        stallreq_id_i = 1'b1; flush_i = 1'b1; ex_mc_req_i = 1'b1;
        settle();
        check("rst_stall", 32'(stall_o), 32'h00);
        check("rst_flush", 32'(flush_o), 32'h0);
        step();
        stallreq_id_i = 1'b0; flush_i = 1'b0; ex_mc_req_i = 1'b0;
        settle();
        check("rst_state", 32'(mc_state_o), 32'd0);
        check("rst_pulses", {28'd0, mc_start_o, mc_cancel_o, mc_result_valid_o, mc_error_o}, 32'h0);
        rst = 1'b0;
        step();
        settle();
        check("idle_stall", 32'(stall_o), 32'h00);
        check("idle_state", 32'(mc_state_o), 32'd0);

        // Load-use in IDLE
        stallreq_id_i = 1'b1;
        settle();
        check("lu_stall", 32'(stall_o), 32'h07);
        step();
        stallreq_id_i = 1'b0;
        settle();
        check("lu_stall_next", 32'(stall_o), 32'h00);
        check("lu_state", 32'(mc_state_o), 32'd0);

        // Div sequence: req at cycle 0, done pulse at cycle 10
        ex_mc_req_i = 1'b1;
        settle();
        check("div_c0_stall", 32'(stall_o), 32'h0F);
        step();
        settle();
        check("div_c1_state", 32'(mc_state_o), 32'd1);
        check("div_c1_start", 32'(mc_start_o), 32'd1);
        check("div_c1_stall", 32'(stall_o), 32'h0F);
        for (int c = 2; c <= 9; c++) begin
            step();
            settle();
            check("div_busy_state", 32'(mc_state_o), 32'd2);
            check("div_busy_start", 32'(mc_start_o), 32'd0);
            check("div_busy_stall", 32'(stall_o), 32'h0F);
        end
        step();
        mc_done_i = 1'b1;
        settle();
        check("div_c10_stall", 32'(stall_o), 32'h0F);
        step();
        mc_done_i = 1'b0;
        settle();
        check("div_c11_state", 32'(mc_state_o), 32'd3);
        check("div_c11_valid", 32'(mc_result_valid_o), 32'd1);
        check("div_c11_stall", 32'(stall_o), 32'h00);
        stallreq_id_i = 1'b1;
        settle();
        check("done_lu_stall", 32'(stall_o), 32'h07);
        step();
        stallreq_id_i = 1'b0; ex_mc_req_i = 1'b0;
        settle();
        check("div_c12_state", 32'(mc_state_o), 32'd0);
        check("div_c12_valid", 32'(mc_result_valid_o), 32'd0);
        check("div_c12_stall", 32'(stall_o), 32'h00);

        // Timeout: no done ever arrives
        ex_mc_req_i = 1'b1;
        step();
        settle();
        check("to_start_state", 32'(mc_state_o), 32'd1);
        for (int c = 2; c <= MC_TIMEOUT + 1; c++) begin
            step();
            settle();
            check("to_busy_state", 32'(mc_state_o), 32'd2);
            check("to_busy_err", 32'(mc_error_o), 32'd0);
        end
        step();
        ex_mc_req_i = 1'b0;
        settle();
        check("to_state", 32'(mc_state_o), 32'd0);
        check("to_error", 32'(mc_error_o), 32'd1);
        check("to_cancel", 32'(mc_cancel_o), 32'd1);
        check("to_stall", 32'(stall_o), 32'h00);
        step();
        settle();
        check("to_err_pulse", 32'(mc_error_o), 32'd0);
        check("to_cancel_pulse", 32'(mc_cancel_o), 32'd0);

        // Flush mid-BUSY, then a late done
        ex_mc_req_i = 1'b1;
        step();
        step();
        for (int c = 3; c <= 7; c++) step();
        flush_i = 1'b1;
        settle();
        check("fl_state_before", 32'(mc_state_o), 32'd2);
        check("fl_flush_o", 32'(flush_o), 32'd1);
        check("fl_stall", 32'(stall_o), 32'h00);
        step();
        flush_i = 1'b0; ex_mc_req_i = 1'b0; mc_done_i = 1'b1;
        settle();
        check("fl_cancel", 32'(mc_cancel_o), 32'd1);
        check("fl_state", 32'(mc_state_o), 32'd0);
        check("fl_start_cancel_excl", 32'(mc_start_o), 32'd0);
        step();
        mc_done_i = 1'b0;
        settle();
        check("fl_late_done_state", 32'(mc_state_o), 32'd0);
        check("fl_late_done_valid", 32'(mc_result_valid_o), 32'd0);
        check("fl_cancel_pulse", 32'(mc_cancel_o), 32'd0);

        // Flush in IDLE with a pending EX request blocks START
        ex_mc_req_i = 1'b1; flush_i = 1'b1;
        settle();
        check("fli_stall", 32'(stall_o), 32'h00);
        check("fli_flush_o", 32'(flush_o), 32'd1);
        step();
        ex_mc_req_i = 1'b0; flush_i = 1'b0;
        settle();
        check("fli_state", 32'(mc_state_o), 32'd0);
        check("fli_start", 32'(mc_start_o), 32'd0);

        // Flush in DONE: result still valid, no cancel
        ex_mc_req_i = 1'b1;
        step();
        step();
        mc_done_i = 1'b1;
        step();
        mc_done_i = 1'b0; flush_i = 1'b1;
        settle();
        check("fld_state", 32'(mc_state_o), 32'd3);
        check("fld_valid", 32'(mc_result_valid_o), 32'd1);
        check("fld_flush_o", 32'(flush_o), 32'd1);
        step();
        flush_i = 1'b0; ex_mc_req_i = 1'b0;
        settle();
        check("fld_cancel", 32'(mc_cancel_o), 32'd0);
        check("fld_state_after", 32'(mc_state_o), 32'd0);

        // Simultaneous ID and EX requests: EX wins
        stallreq_id_i = 1'b1; ex_mc_req_i = 1'b1;
        settle();
        check("sim_stall", 32'(stall_o), 32'h0F);
        step();
        stallreq_id_i = 1'b0;
        settle();
        check("sim_state", 32'(mc_state_o), 32'd1);
        check("sim_start", 32'(mc_start_o), 32'd1);

        // Reset during BUSY: back to IDLE with no cancel
        step();
        step();
        settle();
        check("rb_state_before", 32'(mc_state_o), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0; ex_mc_req_i = 1'b0;
        settle();
        check("rb_state", 32'(mc_state_o), 32'd0);
        check("rb_cancel", 32'(mc_cancel_o), 32'd0);
        step();
        settle();
        check("rb_cancel_next", 32'(mc_cancel_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the five-stage core (pc, if_id, id, id_ex, ex, ex_mem, mem, mem_wb).
- Merges stall requests from ID (load-use) and EX (multi-cycle op), and drives one 6-bit stall vector to every pipeline register.
- Sequences an external iterative unit (divider / multi-cycle MAC) through a start/done handshake, with a timeout.
- Turns an exception flush request into a pipeline-wide flush that cancels any in-flight multi-cycle op.

Parameters:
- STALL_W, 6: stall vector width. Bit 0 pc, 1 if_id, 2 id_ex input (ID), 3 EX, 4 ex_mem/MEM, 5 mem_wb/WB.
- CNT_W, 6: width of the busy-cycle counter.
- MC_TIMEOUT, 40: max BUSY cycles before abort; must be < 2^CNT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stallreq_id_i  in  1  ID load-use hazard; level, valid the same cycle.
- ex_mc_req_i  in  1  EX holds a multi-cycle op; level, stays high while that instruction sits in EX.
- mc_done_i  in  1  iterative unit result ready; single-cycle pulse.
- flush_i  in  1  exception/flush request; single-cycle pulse.
- stall_o  out  STALL_W  hold vector; combinational.
- flush_o  out  1  clear all pipeline registers; combinational, equals flush_i.
- mc_start_o  out  1  start pulse to the iterative unit; registered.
- mc_cancel_o  out  1  abort pulse to the iterative unit; registered.
- mc_result_valid_o  out  1  EX may latch the unit result this cycle; registered.
- mc_error_o  out  1  timeout pulse; registered.
- mc_state_o  out  2  FSM state for debug.

Behaviour:
- Reset: state IDLE, counter 0. mc_start_o, mc_cancel_o, mc_result_valid_o and mc_error_o are 0, and mc_state_o is 0. While rst=1, stall_o=0 and flush_o=0 regardless of inputs.
- State encoding: IDLE=0, START=1, BUSY=2, DONE=3.
- stall_o priority, first match wins:
  - flush_i=1: 000000.
  - state is START or BUSY, or (IDLE and ex_mc_req_i=1): 001111.
  - stallreq_id_i=1: 000111.
  - otherwise 000000.
- stall_o in DONE: 000000, unless stallreq_id_i=1, which gives 000111.
- IDLE:
  - ex_mc_req_i=1 and flush_i=0: go to START. Stall is already asserted this cycle.
  - Otherwise stay in IDLE.
- START:
  - mc_start_o=1 for exactly this cycle.
  - Counter cleared to 0.
  - Next state BUSY.
- BUSY:
  - Counter increments each cycle.
  - mc_done_i=1: go to DONE.
  - Otherwise, counter reaching MC_TIMEOUT-1: go to IDLE, with mc_error_o=1 and mc_cancel_o=1 for one cycle in that next cycle.
  - If done and timeout coincide, done wins.
- DONE:
  - mc_result_valid_o=1 and stall released, so the op advances into ex_mem on this edge.
  - Next state is IDLE unconditionally. ex_mc_req_i is still high from the departing instruction and is ignored in DONE.
  - A back-to-back multi-cycle op is seen in IDLE on the following cycle (one bubble cycle minimum between ops).
- mc_done_i outside BUSY: ignored.
- flush_i=1 in any state: next state IDLE and counter cleared.
  - Flush in START or BUSY: mc_cancel_o=1 in the next cycle.
  - Flush in DONE: no cancel (result already delivered). mc_result_valid_o still asserts in DONE, because flush_o clears ex_mem.
- Flush in IDLE with ex_mc_req_i=1: START is not entered.
- Registered pulse outputs are at most one cycle wide. mc_start_o and mc_cancel_o are never high together.
- Synchronous reset mid-operation (START/BUSY): returns to IDLE without asserting mc_cancel_o. The unit is reset by the same rst.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all inputs 0 -> all outputs 0, mc_state_o=0.
- Load-use: stallreq_id_i=1 for one cycle in IDLE -> stall_o=000111 that cycle, 000000 next. No FSM change.
- Div sequence: ex_mc_req_i high at cycle 0, mc_done_i pulse at cycle 10 ->
  - stall_o=001111 for cycles 0–10.
  - mc_start_o=1 at cycle 1 only.
  - DONE at cycle 11 with mc_result_valid_o=1 and stall_o=000000.
  - IDLE at cycle 12.
- Timeout: ex_mc_req_i held high, no mc_done_i -> START at cycle 1, BUSY from cycle 2. At cycle 2+MC_TIMEOUT, mc_error_o=1, mc_cancel_o=1 and state is IDLE.
- Flush mid-BUSY: flush_i pulse at cycle 5 of BUSY ->
  - flush_o=1 and stall_o=000000 that cycle.
  - Next cycle mc_cancel_o=1 and state IDLE.
  - A late mc_done_i one cycle later is ignored.
- Simultaneous requests: stallreq_id_i=1 and ex_mc_req_i=1 in IDLE -> stall_o=001111 (EX wins), FSM enters START.
